// File: rtl/tt_um_bmsce_sar_search.sv
// rtl/tt_um_bmsce_sar_search.sv - binary-search initiator driving the magnitude-comparator tile
// Define BMSCE_SAR_TRACE_EN to expose the FSM state code on uio_out[7:6] and drive all uio pins.
module tt_um_bmsce_sar_search #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] MAX_CMP     = 4'(WIDTH + 1);
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

   state_t           state;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] guess;
   logic [3:0]       count;
   logic [3:0]       settle_cnt;
   logic             found;
   logic             error;
   logic             busy;
   logic             done;

   logic             start_s1;
   logic             start_s2;
   logic             start_d;
   logic             start_rise;
   logic [WIDTH:0]   mid_sum;
   logic [2:0]       flags;
   logic [3:0]       count_nxt;
   logic [5:0]       guess_pad;
   logic [1:0]       trace_code;
   logic             unused_inputs;

   assign start_rise    = start_s2 & ~start_d;
   assign mid_sum       = {1'b0, lo} + {1'b0, hi};
   assign flags         = ui_in[2:0];
   assign count_nxt     = count + 4'd1;
   assign unused_inputs = &{1'b0, ena, uio_in, ui_in[6:3]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_s1 <= 1'b0;
         start_s2 <= 1'b0;
         start_d  <= 1'b0;
      end else begin
         start_s1 <= ui_in[7];
         start_s2 <= start_s1;
         start_d  <= start_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         lo         <= '0;
         hi         <= '0;
         guess      <= '0;
         count      <= 4'd0;
         settle_cnt <= 4'd0;
         found      <= 1'b0;
         error      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start_rise) begin
                  lo    <= '0;
                  hi    <= '1;
                  count <= 4'd0;
                  found <= 1'b0;
                  error <= 1'b0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               guess      <= mid_sum[WIDTH:1];
               settle_cnt <= SETTLE_INIT;
               state      <= S_SETTLE;
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt - 4'd1;
               if (settle_cnt <= 4'd1) state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               count <= count_nxt;
               // Bound checks stop the search before lo/hi could wrap.
               if (!$onehot(flags)) begin
                  error <= 1'b1;
                  found <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (flags[1]) begin
                  found <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (flags[0]) begin
                  if (guess == lo || count_nxt >= MAX_CMP) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     hi    <= guess - 1'b1;
                     state <= S_DRIVE;
                  end
               end else begin
                  if (guess == hi || count_nxt >= MAX_CMP) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     lo    <= guess + 1'b1;
                     state <= S_DRIVE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      guess_pad             = 6'd0;
      guess_pad[WIDTH-1:0]  = guess;
   end

`ifdef BMSCE_SAR_TRACE_EN
   always_comb begin
      trace_code = 2'd0;
      case (state)
         S_DRIVE, S_SETTLE: trace_code = 2'd1;
         S_SAMPLE:          trace_code = 2'd2;
         S_DONE:            trace_code = 2'd3;
         default:           trace_code = 2'd0;
      endcase
   end
   assign uio_oe = 8'hFF;
`else
   assign trace_code = 2'd0;
   assign uio_oe     = 8'h3F;
`endif

   assign uo_out  = {busy, done, guess_pad};
   assign uio_out = {trace_code, error, found, count};

endmodule

// File: tb/tb_tt_um_bmsce_sar_search.sv
// tb/tb_tt_um_bmsce_sar_search.sv - directed table-driven bench with a behavioural comparator
module tb_tt_um_bmsce_sar_search;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] flags;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   int         target;
   int         mode;
   int         n_checks;
   int         n_fail;
   int         guess_log[$];
   logic [3:0] prev_cnt;

   typedef struct {
      int target;
      int mode;
      bit mid_start;
      int n;
      int g[6];
      bit found;
      bit err;
      int cnt;
      int fguess;
   } vec_t;

   vec_t vecs[6];

   tt_um_bmsce_sar_search dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (1'b1),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (8'h00),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comparator model: mode 1 answers an illegal GT+EQ, mode 2 always answers LT.
   always_comb begin
      flags = 3'b000;
      if (mode == 1)                       flags = 3'b011;
      else if (mode == 2)                  flags = 3'b100;
      else if (int'(uo_out[3:0]) == target) flags = 3'b010;
      else if (int'(uo_out[3:0]) > target)  flags = 3'b001;
      else                                 flags = 3'b100;
   end

   assign ui_in = {start, 4'b0000, flags};

   always @(negedge clk) begin
      if (uio_out[3:0] != prev_cnt && uio_out[3:0] != 4'd0)
         guess_log.push_back(int'(uo_out[3:0]));
      prev_cnt = uio_out[3:0];
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      int lat;
      int bcyc;
      bit tmo;
      string tag;
      tag    = $sformatf("v%0d_T%0d", idx, v.target);
      target = v.target;
      mode   = v.mode;
      guess_log.delete();
      lat  = 0;
      bcyc = 0;
      tmo  = 1'b0;
      @(negedge clk);
      start = 1'b1;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 2) start = 1'b0;
         if (uo_out[7]) break;
      end
      start = 1'b0;
      check({tag, "_start_latency"}, lat, 3);
      if (uo_out[7]) begin
         bcyc = 1;
         while (1) begin
            @(negedge clk);
            if (v.mid_start && bcyc == 6) start = 1'b1;
            if (v.mid_start && bcyc == 8) start = 1'b0;
            if (!uo_out[7]) break;
            bcyc++;
            if (bcyc > 200) begin
               tmo = 1'b1;
               break;
            end
         end
      end else begin
         tmo = 1'b1;
      end
      start = 1'b0;
      #1;
      check({tag, "_timeout"}, int'(tmo), 0);
      check({tag, "_busy_cycles"}, bcyc, v.cnt * 4);
      check({tag, "_n_guesses"}, guess_log.size(), v.n);
      for (int i = 0; i < v.n; i++)
         check($sformatf("%s_guess%0d", tag, i), (i < guess_log.size()) ? guess_log[i] : -1, v.g[i]);
      check({tag, "_done"},   int'(uo_out[6]),   1);
      check({tag, "_busy"},   int'(uo_out[7]),   0);
      check({tag, "_result"}, int'(uo_out[3:0]), v.fguess);
      check({tag, "_pad"},    int'(uo_out[5:4]), 0);
      check({tag, "_count"},  int'(uio_out[3:0]), v.cnt);
      check({tag, "_found"},  int'(uio_out[4]),  int'(v.found));
      check({tag, "_error"},  int'(uio_out[5]),  int'(v.err));
      check({tag, "_trace"},  int'(uio_out[7:6]), 0);
      repeat (3) @(negedge clk);
      check({tag, "_done_held"},   int'(uo_out[6]),   1);
      check({tag, "_result_held"}, int'(uo_out[3:0]), v.fguess);
      check({tag, "_count_held"},  int'(uio_out[3:0]), v.cnt);
   endtask

   initial begin
      int k;
      n_checks = 0;
      n_fail   = 0;
      prev_cnt = 4'd0;
      rst_n    = 1'b0;
      start    = 1'b0;
      target   = 0;
      mode     = 0;

      //        target mode mid  n   guesses                 found err cnt result
      vecs[0] = '{11, 0, 1'b0, 2, '{7, 11, 0, 0, 0, 0},    1'b1, 1'b0, 2, 11};
      vecs[1] = '{0,  0, 1'b0, 4, '{7, 3, 1, 0, 0, 0},     1'b1, 1'b0, 4, 0};
      vecs[2] = '{15, 0, 1'b0, 5, '{7, 11, 13, 14, 15, 0}, 1'b1, 1'b0, 5, 15};
      vecs[3] = '{9,  1, 1'b0, 1, '{7, 0, 0, 0, 0, 0},     1'b0, 1'b1, 1, 7};
      vecs[4] = '{3,  2, 1'b1, 5, '{7, 11, 13, 14, 15, 0}, 1'b0, 1'b0, 5, 15};
      vecs[5] = '{5,  0, 1'b0, 3, '{7, 3, 5, 0, 0, 0},     1'b1, 1'b0, 3, 5};

      repeat (3) @(negedge clk);
      check("reset_uo_out",  int'(uo_out),  0);
      check("reset_uio_out", int'(uio_out), 0);
      check("reset_uio_oe",  int'(uio_oe),  'h3F);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_uo_out", int'(uo_out), 0);

      for (int i = 0; i < 5; i++) apply(vecs[i], i);

      // Abort during SETTLE of the second compare.
      target = 5;
      mode   = 0;
      start  = 1'b1;
      k      = 0;
      while (uio_out[3:0] != 4'd1 && k < 100) begin
         @(negedge clk);
         k++;
         if (k == 2) start = 1'b0;
      end
      start = 1'b0;
      check("abort_reached_cmp1", int'(uio_out[3:0]), 1);
      @(negedge clk);
      check("abort_busy_before", int'(uo_out[7]), 1);
      rst_n = 1'b0;
      #1;
      check("abort_uo_out",  int'(uo_out),  0);
      check("abort_uio_out", int'(uio_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      apply(vecs[5], 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule
